regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (rf_w/waddr/wdata) between NREQ

---
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the execution units and the register-file write arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic               hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_waddr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic               rf_w;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;
    logic [2:0]         grant_id;
    logic               busy;

    modport master (
        output hold, req_valid, req_waddr, req_wdata,
        input  req_ready, rf_w, waddr, wdata, grant_id, busy
    );

    modport slave (
        input  hold, req_valid, req_waddr, req_wdata,
        output req_ready, rf_w, waddr, wdata, grant_id, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources.
// The winning write is registered; writes to $0 finish the handshake without asserting rf_w.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic clk,
    input  logic reset,
    regfile_wb_arbiter_if.slave bus
);

    logic [2:0]      last_p1;
    logic            vld_p1;
    logic [AW-1:0]   waddr_p1;
    logic [DW-1:0]   wdata_p1;
    logic [2:0]      grant_p1;

    logic [2:0]      win_idx_p0;
    logic            win_vld_p0;
    logic            accept_p0;
    logic [NREQ-1:0] ready_p0;
    logic [AW-1:0]   sel_addr_p0;
    logic [DW-1:0]   sel_data_p0;
    int              last_i;

    // p0: round-robin search starting just after the last winner
    assign last_i = int'(last_p1);

    always_comb begin
        win_idx_p0 = '0;
        win_vld_p0 = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!win_vld_p0 && bus.req_valid[i] && ((last_i + k) % NREQ == i)) begin
                    win_idx_p0 = 3'(i);
                    win_vld_p0 = 1'b1;
                end
            end
        end
    end

    assign accept_p0 = win_vld_p0 && !bus.hold && reset;

    always_comb begin
        ready_p0    = '0;
        sel_addr_p0 = '0;
        sel_data_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_p0 == 3'(i)) begin
                ready_p0[i] = accept_p0;
                sel_addr_p0 = bus.req_waddr[i*AW +: AW];
                sel_data_p0 = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    assign bus.req_ready = ready_p0;
    assign bus.busy      = |(bus.req_valid & ~ready_p0);

    // p1: registered write port; pointer and address/data only move on an accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            grant_p1 <= '0;
            last_p1  <= 3'(NREQ - 1);
        end else if (accept_p0) begin
            vld_p1   <= (sel_addr_p0 != '0);
            waddr_p1 <= sel_addr_p0;
            wdata_p1 <= sel_data_p0;
            grant_p1 <= win_idx_p0;
            last_p1  <= win_idx_p0;
        end else begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.rf_w     = vld_p1;
    assign bus.waddr    = waddr_p1;
    assign bus.wdata    = wdata_p1;
    assign bus.grant_id = grant_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected write-port results are queued when
// each cycle's stimulus is applied and compared after the following posedge.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    gid;
    } wr_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    int   m_last;
    wr_t  m_exp;
    wr_t  sb[$];
    logic [DW-1:0] regs [32];

    regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) rf_if ();

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: commits at the negedge inside the rf_w cycle
    always @(negedge clk) begin
        if (rf_if.rf_w) regs[rf_if.waddr] <= rf_if.wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rf_if.req_valid[i]         = v;
        rf_if.req_waddr[i*AW +: AW] = a;
        rf_if.req_wdata[i*DW +: DW] = d;
    endtask

    // One clock: check handshake against the model, queue expected write, compare after posedge
    task automatic step();
        wr_t e;
        int win;
        logic [NREQ-1:0] er;
        #1;
        win = -1;
        if (reset) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (win < 0 && rf_if.req_valid[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
            end
        end
        er = '0;
        if (win >= 0 && !rf_if.hold) er[win] = 1'b1;
        check_eq("req_ready", 64'(rf_if.req_ready), 64'(er));
        check_eq("busy", 64'(rf_if.busy), 64'(|(rf_if.req_valid & ~er)));
        if (!reset) begin
            m_exp  = '0;
            m_last = NREQ - 1;
        end else if (er != '0) begin
            m_exp.addr = rf_if.req_waddr[win*AW +: AW];
            m_exp.data = rf_if.req_wdata[win*DW +: DW];
            m_exp.we   = (m_exp.addr != '0);
            m_exp.gid  = 3'(win);
            m_last     = win;
        end else begin
            m_exp.we = 1'b0;
        end
        sb.push_back(m_exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("rf_w", 64'(rf_if.rf_w), 64'(e.we));
        check_eq("waddr", 64'(rf_if.waddr), 64'(e.addr));
        check_eq("wdata", 64'(rf_if.wdata), 64'(e.data));
        check_eq("grant_id", 64'(rf_if.grant_id), 64'(e.gid));
    endtask

    initial begin
        logic [2:0] seq [4];
        n_vec  = 0;
        n_miss = 0;
        m_last = NREQ - 1;
        m_exp  = '0;
        for (int r = 0; r < 32; r++) regs[r] = '0;
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd0;

        // Reset held two cycles with everything valid
        reset      = 1'b0;
        rf_if.hold = 1'b0;
        set_req(0, 1'b1, 5'd1, 32'hA1);
        set_req(1, 1'b1, 5'd2, 32'hB2);
        set_req(2, 1'b1, 5'd3, 32'hC3);
        for (int c = 0; c < 2; c++) begin
            step();
            check_eq("rst_ready", 64'(rf_if.req_ready), 64'd0);
        end
        check_eq("rst_rf_w", 64'(rf_if.rf_w), 64'd0);

        // All valid: rotation 0,1,2,0
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("rr_seq", 64'(rf_if.grant_id), 64'(seq[c]));
            check_eq("rr_rf_w", 64'(rf_if.rf_w), 64'd1);
        end
        rf_if.req_valid = '0;
        step();
        check_eq("rd_r1", 64'(regs[1]), 64'hA1);
        check_eq("rd_r2", 64'(regs[2]), 64'hB2);
        check_eq("rd_r3", 64'(regs[3]), 64'hC3);

        // Write to $0 completes but never writes
        set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        check_eq("z_rf_w", 64'(rf_if.rf_w), 64'd0);
        check_eq("z_gid", 64'(rf_if.grant_id), 64'd0);
        rf_if.req_valid = '0;
        step();
        check_eq("z_rd_r0", 64'(regs[0]), 64'd0);

        // Single requester 2, three cycles
        set_req(2, 1'b1, 5'd7, 32'h0000_0077);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("solo_gid", 64'(rf_if.grant_id), 64'd2);
            check_eq("solo_rf_w", 64'(rf_if.rf_w), 64'd1);
        end
        rf_if.req_valid = '0;

        // Hold with req0/req1 pending, then release
        set_req(0, 1'b1, 5'd4, 32'h0000_0044);
        set_req(1, 1'b1, 5'd5, 32'h0000_0055);
        rf_if.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("hold_busy", 64'(rf_if.busy), 64'd1);
            check_eq("hold_rf_w", 64'(rf_if.rf_w), 64'd0);
        end
        rf_if.hold = 1'b0;
        step();
        check_eq("hold_first", 64'(rf_if.grant_id), 64'd0);

        // Reset lands in the cycle req1 would win
        reset = 1'b0;
        step();
        check_eq("midrst_rf_w", 64'(rf_if.rf_w), 64'd0);
        reset = 1'b1;
        step();
        check_eq("post_rst_gid", 64'(rf_if.grant_id), 64'd0);
        step();
        check_eq("post_rst_gid2", 64'(rf_if.grant_id), 64'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            end
            rf_if.hold = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
